// File: rtl/calc_key_entry_if.sv
// Keypad-to-calculator bundle: raw key level/code in, operands/operator/status out.
// The slave modport is the key-entry block; the master modport is the keypad/consumer side.
interface calc_key_entry_if;
  logic       key_raw;
  logic [3:0] key_code;
  logic [3:0] num1;
  logic [3:0] num2;
  logic [3:0] select;
  logic       result_valid;
  logic       done;
  logic       key_ack;
  logic       err;
  logic [2:0] state;

  modport master (
    output key_raw, key_code,
    input  num1, num2, select, result_valid, done, key_ack, err, state
  );

  modport slave (
    input  key_raw, key_code,
    output num1, num2, select, result_valid, done, key_ack, err, state
  );
endinterface

// File: rtl/calc_key_entry.sv
// Calculator key entry: synchronize + debounce a bouncing keypad, then walk
// an operand/operator/operand/equals FSM with ack/err/done pulses.
module calc_key_entry #(
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  calc_key_entry_if.slave  kif
);

  typedef enum logic [2:0] {
    S_N1   = 3'd0,
    S_OP   = 3'd1,
    S_N2   = 3'd2,
    S_EQ   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [7:0] DEB     = 8'(DEB_CYCLES);
  localparam logic [3:0] K_EQ    = 4'd14;
  localparam logic [3:0] K_CLR   = 4'd15;

  logic [1:0] raw_sync_q;
  logic [3:0] code_s1_q, code_s2_q, code_prev_q;
  logic       raw_s;
  logic [7:0] cnt_q, cnt_d, rel_q, rel_d;
  logic       armed_q, armed_d;
  logic       press_q, press_d;
  logic [3:0] pcode_q;

  state_e     state_q, state_d;
  logic [3:0] num1_q, num1_d, num2_q, num2_d, sel_q, sel_d;
  logic       done_q, done_d, err_q, err_d;

  assign raw_s = raw_sync_q[1];

  // Press count restarts on any code change; release count must fill before re-arming.
  always_comb begin
    cnt_d   = '0;
    rel_d   = '0;
    armed_d = armed_q;
    press_d = 1'b0;
    if (raw_s) begin
      if (cnt_q == 8'd0 || code_s2_q != code_prev_q) cnt_d = 8'd1;
      else if (cnt_q != DEB)                         cnt_d = cnt_q + 8'd1;
      else                                           cnt_d = cnt_q;
      if (armed_q && cnt_d == DEB) begin
        press_d = 1'b1;
        armed_d = 1'b0;
      end
    end else begin
      rel_d = (rel_q == DEB) ? rel_q : rel_q + 8'd1;
      if (rel_d == DEB) armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_sync_q  <= '0;
      code_s1_q   <= '0;
      code_s2_q   <= '0;
      code_prev_q <= '0;
      cnt_q       <= '0;
      rel_q       <= '0;
      armed_q     <= 1'b0;
      press_q     <= 1'b0;
      pcode_q     <= '0;
    end else begin
      raw_sync_q  <= {raw_sync_q[0], kif.key_raw};
      code_s1_q   <= kif.key_code;
      code_s2_q   <= code_s1_q;
      code_prev_q <= code_s2_q;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      armed_q     <= armed_d;
      press_q     <= press_d;
      if (press_d) pcode_q <= code_s2_q;
    end
  end

  logic       is_digit, is_op;
  logic [3:0] op_idx;
  assign is_digit = (pcode_q <= 4'd9);
  assign is_op    = (pcode_q >= 4'd10) && (pcode_q <= 4'd13);
  assign op_idx   = pcode_q - 4'd10;

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_N1, S_OP, S_N2, S_EQ, S_DONE: begin
        if (press_q) begin
          if (pcode_q == K_CLR) begin
            num1_d  = '0;
            num2_d  = '0;
            sel_d   = '0;
            state_d = S_N1;
          end else if (is_digit) begin
            case (state_q)
              S_N1:    begin num1_d = pcode_q; state_d = S_OP; end
              S_OP:    num1_d = pcode_q;
              S_N2:    begin num2_d = pcode_q; state_d = S_EQ; end
              S_EQ:    num2_d = pcode_q;
              default: begin
                num1_d  = pcode_q;
                num2_d  = '0;
                sel_d   = '0;
                state_d = S_OP;
              end
            endcase
          end else if (is_op) begin
            if (state_q == S_OP || state_q == S_N2) begin
              sel_d   = 4'b0001 << op_idx[1:0];
              state_d = S_N2;
            end else begin
              err_d = 1'b1;
            end
          end else if (pcode_q == K_EQ) begin
            if (state_q == S_EQ) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = S_N1;  // codes 5-7 are unreachable; fall back to a clean start
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_N1;
      num1_q  <= '0;
      num2_q  <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign kif.num1         = num1_q;
  assign kif.num2         = num2_q;
  assign kif.select       = sel_q;
  assign kif.state        = state_q;
  assign kif.result_valid = (state_q == S_DONE);
  assign kif.done         = done_q;
  assign kif.err          = err_q;
  assign kif.key_ack      = press_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: table-driven press vectors, hand-written bounce/reset
// sequences, and random presses checked against a rule-level model.
module tb_calc_key_entry;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_key_entry_if kif ();
  calc_key_entry #(.DEB_CYCLES(DEB)) dut (.clk(clk), .rst_n(rst_n), .kif(kif));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int st, input int n1, input int n2, input int sel);
    check({tag, ".state"}, int'(kif.state), st);
    check({tag, ".num1"},  int'(kif.num1),  n1);
    check({tag, ".num2"},  int'(kif.num2),  n2);
    check({tag, ".select"}, int'(kif.select), sel);
    check({tag, ".result_valid"}, int'(kif.result_valid), (st == 4) ? 1 : 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_outputs(tag, 0, 0, 0, 0);
    check({tag, ".done"}, int'(kif.done), 0);
    check({tag, ".key_ack"}, int'(kif.key_ack), 0);
    check({tag, ".err"}, int'(kif.err), 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Clean press: rise just after an edge (edge 1 is the next one), hold, release, let it re-arm.
  task automatic press(input int code, input int st, input int n1, input int n2, input int sel,
                       input int e_err, input int e_done, input string tag);
    int acks, ack_edge, errs, dones, both;
    acks = 0; ack_edge = -1; errs = 0; dones = 0; both = 0;
    kif.key_code = 4'(code);
    kif.key_raw  = 1'b1;
    for (int k = 1; k <= DEB + 8; k++) begin
      @(posedge clk); #1;
      if (kif.key_ack) begin acks++; ack_edge = k; end
      errs  += int'(kif.err);
      dones += int'(kif.done);
      if (kif.err && kif.done) both++;
      if (k == DEB + 3) check_outputs(tag, st, n1, n2, sel);
    end
    kif.key_raw = 1'b0;
    for (int k = 0; k < DEB + 6; k++) begin
      @(posedge clk); #1;
      if (kif.key_ack) acks++;
      errs  += int'(kif.err);
      dones += int'(kif.done);
    end
    check({tag, ".acks"}, acks, 1);
    check({tag, ".ack_edge"}, ack_edge, DEB + 2);
    check({tag, ".err"}, errs, e_err);
    check({tag, ".done"}, dones, e_done);
    check({tag, ".err_and_done"}, both, 0);
  endtask

  typedef struct {
    int code, st, n1, n2, sel, er, dn;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: entry rules applied directly to operand/operator variables.
  int m_st, m_n1, m_n2, m_sel;
  task automatic model(input int c, output int er, output int dn);
    er = 0; dn = 0;
    if (c == 15) begin
      m_st = 0; m_n1 = 0; m_n2 = 0; m_sel = 0;
    end else if (c < 10) begin
      if (m_st == 0 || m_st == 1) begin m_n1 = c; m_st = 1; end
      else if (m_st == 2 || m_st == 3) begin m_n2 = c; m_st = 3; end
      else begin m_n1 = c; m_n2 = 0; m_sel = 0; m_st = 1; end
    end else if (c < 14) begin
      if (m_st == 1 || m_st == 2) begin m_sel = 1 << (c - 10); m_st = 2; end
      else er = 1;
    end else begin
      if (m_st == 3) begin m_st = 4; dn = 1; end
      else er = 1;
    end
  endtask

  initial begin
    int acks, er, dn, c;
    kif.key_raw  = 1'b0;
    kif.key_code = 4'd0;

    vecs = '{
      '{14, 0, 0, 0, 0, 1, 0},   // EQ in S_N1
      '{ 3, 1, 3, 0, 0, 0, 0},
      '{10, 2, 3, 0, 1, 0, 0},
      '{ 5, 3, 3, 5, 1, 0, 0},
      '{14, 4, 3, 5, 1, 0, 1},
      '{12, 4, 3, 5, 1, 1, 0},   // operator in S_DONE
      '{ 9, 1, 9, 0, 0, 0, 0},   // restart from S_DONE
      '{ 7, 1, 7, 0, 0, 0, 0},
      '{11, 2, 7, 0, 2, 0, 0},
      '{13, 2, 7, 0, 8, 0, 0},
      '{ 2, 3, 7, 2, 8, 0, 0},
      '{ 4, 3, 7, 4, 8, 0, 0},
      '{12, 3, 7, 4, 8, 1, 0},   // MUL in S_EQ keeps select
      '{15, 0, 0, 0, 0, 0, 0},   // CLR from S_EQ
      '{ 6, 1, 6, 0, 0, 0, 0},
      '{14, 1, 6, 0, 0, 1, 0},
      '{15, 0, 0, 0, 0, 0, 0}
    };

    #3;
    check_reset_state("reset");
    idle(2);
    rst_n = 1'b1;
    idle(DEB + 4);

    foreach (vecs[i])
      press(vecs[i].code, vecs[i].st, vecs[i].n1, vecs[i].n2, vecs[i].sel,
            vecs[i].er, vecs[i].dn, $sformatf("vec%0d", i));

    // Bounce: 3 high, 1 low, 3 high -- never reaches the debounce count.
    press(8, 1, 8, 0, 0, 0, 0, "pre_bounce");
    acks = 0;
    kif.key_code = 4'd3;
    kif.key_raw = 1'b1; for (int k = 0; k < 3; k++) begin @(posedge clk); #1; acks += int'(kif.key_ack); end
    kif.key_raw = 1'b0; @(posedge clk); #1; acks += int'(kif.key_ack);
    kif.key_raw = 1'b1; for (int k = 0; k < 3; k++) begin @(posedge clk); #1; acks += int'(kif.key_ack); end
    kif.key_raw = 1'b0; for (int k = 0; k < 12; k++) begin @(posedge clk); #1; acks += int'(kif.key_ack); end
    check("bounce.acks", acks, 0);
    check_outputs("bounce", 1, 8, 0, 0);

    // Mid-entry reset with a key held and a debounce in progress.
    press(7, 1, 7, 0, 0, 0, 0, "pre_reset");
    kif.key_code = 4'd5;
    kif.key_raw = 1'b1;
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_reset_state("async_reset");
    idle(3);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; acks += int'(kif.key_ack); end
    check("held_through_reset.acks", acks, 0);
    check_outputs("held_through_reset", 0, 0, 0, 0);
    kif.key_raw = 1'b0;
    idle(DEB + 6);
    press(5, 1, 5, 0, 0, 0, 0, "repress");

    // Random presses against the model; CLR first to align the model.
    m_st = 1; m_n1 = 5; m_n2 = 0; m_sel = 0;
    for (int i = 0; i < 40; i++) begin
      c = (i == 0) ? 15 : int'($urandom_range(0, 15));
      if (c == 15 && i != 0 && $urandom_range(0, 1) == 1) c = int'($urandom_range(10, 14));
      model(c, er, dn);
      press(c, m_st, m_n1, m_n2, m_sel, er, dn, $sformatf("rnd%0d_k%0d", i, c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
